// File: rtl/ordenador_pkg.sv
// Shared types and the Batcher odd-even merge network description for the
// 8-operand sorter.
package ordenador_pkg;

  localparam int unsigned WIDTH = 9;
  localparam int unsigned N     = 8;
  localparam int unsigned NCMP  = 19;

  typedef logic [WIDTH-1:0] num_t;
  typedef num_t num_arr_t [N];

  typedef struct packed {
    logic [2:0] level;
    logic [2:0] i;
    logic [2:0] j;
  } cmp_pair_t;

  // Listed in evaluation order; each cell puts min at i and max at j (i < j).
  localparam cmp_pair_t CMP_TABLE [NCMP] = '{
    '{3'd1, 3'd0, 3'd1}, '{3'd1, 3'd2, 3'd3}, '{3'd1, 3'd4, 3'd5}, '{3'd1, 3'd6, 3'd7},
    '{3'd2, 3'd0, 3'd2}, '{3'd2, 3'd1, 3'd3}, '{3'd2, 3'd4, 3'd6}, '{3'd2, 3'd5, 3'd7},
    '{3'd3, 3'd1, 3'd2}, '{3'd3, 3'd5, 3'd6},
    '{3'd4, 3'd0, 3'd4}, '{3'd4, 3'd1, 3'd5}, '{3'd4, 3'd2, 3'd6}, '{3'd4, 3'd3, 3'd7},
    '{3'd5, 3'd2, 3'd4}, '{3'd5, 3'd3, 3'd5},
    '{3'd6, 3'd1, 3'd2}, '{3'd6, 3'd3, 3'd4}, '{3'd6, 3'd5, 3'd6}
  };

endpackage

// File: rtl/ordenador_cmp_swap.sv
// Combinational compare-exchange cell: unsigned min/max of two operands.
module cmp_swap
  import ordenador_pkg::*;
(
  input  num_t a,
  input  num_t b,
  output num_t lo,
  output num_t hi
);

  logic b_lt_a;

  assign b_lt_a = (b < a);
  assign lo     = b_lt_a ? b : a;
  assign hi     = b_lt_a ? a : b;

endmodule

// File: rtl/ordenador_8_numeros_8bits.sv
// Eight-operand sorter: ascending Batcher network, direction reversal mux and
// a registered output bank with enable and asynchronous reset.
module ordenador_8_numeros_8bits
  import ordenador_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             cresc_ou_decres,
  input  logic [WIDTH-1:0] n1_n,
  input  logic [WIDTH-1:0] n2_n,
  input  logic [WIDTH-1:0] n3_n,
  input  logic [WIDTH-1:0] n4_n,
  input  logic [WIDTH-1:0] n5_n,
  input  logic [WIDTH-1:0] n6_n,
  input  logic [WIDTH-1:0] n7_n,
  input  logic [WIDTH-1:0] n8_n,
  output logic [WIDTH-1:0] n1,
  output logic [WIDTH-1:0] n2,
  output logic [WIDTH-1:0] n3,
  output logic [WIDTH-1:0] n4,
  output logic [WIDTH-1:0] n5,
  output logic [WIDTH-1:0] n6,
  output logic [WIDTH-1:0] n7,
  output logic [WIDTH-1:0] n8
);

  num_t     st [NCMP+1][N];
  num_t     lo_w [NCMP];
  num_t     hi_w [NCMP];
  num_arr_t res_d;
  num_arr_t res_q;

  assign st[0][0] = n1_n;
  assign st[0][1] = n2_n;
  assign st[0][2] = n3_n;
  assign st[0][3] = n4_n;
  assign st[0][4] = n5_n;
  assign st[0][5] = n6_n;
  assign st[0][6] = n7_n;
  assign st[0][7] = n8_n;

  // One stage per cell: cell k rewrites its two lanes, all others pass through.
  for (genvar k = 0; k < NCMP; k++) begin : g_cmp
    cmp_swap u_cs (
      .a  (st[k][CMP_TABLE[k].i]),
      .b  (st[k][CMP_TABLE[k].j]),
      .lo (lo_w[k]),
      .hi (hi_w[k])
    );
    for (genvar m = 0; m < N; m++) begin : g_lane
      if (m == int'(CMP_TABLE[k].i)) begin : g_lo
        assign st[k+1][m] = lo_w[k];
      end else if (m == int'(CMP_TABLE[k].j)) begin : g_hi
        assign st[k+1][m] = hi_w[k];
      end else begin : g_pass
        assign st[k+1][m] = st[k][m];
      end
    end
  end

  always_comb begin
    res_d = res_q;
    for (int unsigned m = 0; m < N; m++) begin
      res_d[m] = cresc_ou_decres ? st[NCMP][N-1-m] : st[NCMP][m];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q <= '{default: '0};
    end else if (ena) begin
      res_q <= res_d;
    end
  end

  assign n1 = res_q[0];
  assign n2 = res_q[1];
  assign n3 = res_q[2];
  assign n4 = res_q[3];
  assign n5 = res_q[4];
  assign n6 = res_q[5];
  assign n7 = res_q[6];
  assign n8 = res_q[7];

endmodule

// File: tb/tb_ordenador_8_numeros_8bits.sv
// Self-checking bench for ordenador_8_numeros_8bits: directed vector table,
// hand-written hold/reset/direction sequences and a randomized scoreboard.
module tb_ordenador_8_numeros_8bits;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b0;
  logic       dir = 1'b0;
  logic [8:0] in_v  [8];
  logic [8:0] dut_o [8];

  int unsigned exp_o [8];
  int unsigned cap_in [8];
  logic        cap_dir = 1'b0;
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ordenador_8_numeros_8bits dut (
    .clk(clk), .rst(rst), .ena(ena), .cresc_ou_decres(dir),
    .n1_n(in_v[0]), .n2_n(in_v[1]), .n3_n(in_v[2]), .n4_n(in_v[3]),
    .n5_n(in_v[4]), .n6_n(in_v[5]), .n7_n(in_v[6]), .n8_n(in_v[7]),
    .n1(dut_o[0]), .n2(dut_o[1]), .n3(dut_o[2]), .n4(dut_o[3]),
    .n5(dut_o[4]), .n6(dut_o[5]), .n7(dut_o[6]), .n8(dut_o[7])
  );

  typedef struct packed {
    logic            dir;
    logic [7:0][8:0] in;
    logic [7:0][8:0] exp;
  } vec_t;

  function automatic logic [7:0][8:0] p8(input int a, b, c, d, e, f, g, h);
    logic [7:0][8:0] r;
    r[0] = 9'(a); r[1] = 9'(b); r[2] = 9'(c); r[3] = 9'(d);
    r[4] = 9'(e); r[5] = 9'(f); r[6] = 9'(g); r[7] = 9'(h);
    return r;
  endfunction

  function automatic void sort_vals(input int unsigned src [8], input logic desc,
                                    output int unsigned dst [8]);
    int unsigned q [$];
    for (int i = 0; i < 8; i++) q.push_back(src[i]);
    q.sort();
    if (desc) q.reverse();
    for (int i = 0; i < 8; i++) dst[i] = q[i];
  endfunction

  // Reference model: one rising edge with the inputs/controls present now.
  task automatic tick();
    int unsigned cur [8];
    int unsigned srt [8];
    logic        cap = ena && !rst;
    logic        d   = dir;
    for (int i = 0; i < 8; i++) cur[i] = in_v[i];
    sort_vals(cur, d, srt);
    @(posedge clk);
    #1;
    if (rst) begin
      for (int i = 0; i < 8; i++) exp_o[i] = 0;
    end else if (cap) begin
      exp_o   = srt;
      cap_in  = cur;
      cap_dir = d;
    end
  endtask

  task automatic check_vec(input string name, input int unsigned e [8]);
    logic bad = 1'b0;
    n_checks++;
    for (int i = 0; i < 8; i++) if (dut_o[i] !== 9'(e[i])) bad = 1'b1;
    if (bad) begin
      n_fail++;
      $display("FAIL %s got=%0d,%0d,%0d,%0d,%0d,%0d,%0d,%0d required=%0d,%0d,%0d,%0d,%0d,%0d,%0d,%0d",
               name, dut_o[0], dut_o[1], dut_o[2], dut_o[3], dut_o[4], dut_o[5], dut_o[6], dut_o[7],
               e[0], e[1], e[2], e[3], e[4], e[5], e[6], e[7]);
    end
  endtask

  task automatic check_props(input string name);
    int unsigned got [8];
    int unsigned s_got [8];
    int unsigned s_in [8];
    logic ord_ok = 1'b1;
    logic set_ok = 1'b1;
    for (int i = 0; i < 8; i++) got[i] = dut_o[i];
    for (int i = 0; i < 7; i++)
      if (cap_dir ? (got[i] < got[i+1]) : (got[i] > got[i+1])) ord_ok = 1'b0;
    sort_vals(got, 1'b0, s_got);
    sort_vals(cap_in, 1'b0, s_in);
    for (int i = 0; i < 8; i++) if (s_got[i] != s_in[i]) set_ok = 1'b0;
    n_checks += 2;
    if (!ord_ok) begin
      n_fail++;
      $display("FAIL %s_order got_first=%0d got_last=%0d required=monotonic dir=%0d",
               name, got[0], got[7], cap_dir);
    end
    if (!set_ok) begin
      n_fail++;
      $display("FAIL %s_multiset got_min=%0d got_max=%0d required_min=%0d required_max=%0d",
               name, s_got[0], s_got[7], s_in[0], s_in[7]);
    end
  endtask

  task automatic rand_inputs(input int unsigned maxv);
    for (int i = 0; i < 8; i++) in_v[i] = 9'($urandom_range(maxv, 0));
  endtask

  vec_t        tbl [6];
  int unsigned zeros [8];
  int unsigned held [8];
  int unsigned e8 [8];

  initial begin
    for (int i = 0; i < 8; i++) begin zeros[i] = 0; exp_o[i] = 0; cap_in[i] = 0; end
    tbl[0] = '{1'b0, p8(1,2,3,4,5,6,7,8),          p8(1,2,3,4,5,6,7,8)};
    tbl[1] = '{1'b0, p8(8,7,6,5,4,3,2,1),          p8(1,2,3,4,5,6,7,8)};
    tbl[2] = '{1'b1, p8(8,7,6,5,4,3,2,1),          p8(8,7,6,5,4,3,2,1)};
    tbl[3] = '{1'b0, p8(7,7,7,7,7,7,7,7),          p8(7,7,7,7,7,7,7,7)};
    tbl[4] = '{1'b1, p8(7,7,7,7,7,7,7,7),          p8(7,7,7,7,7,7,7,7)};
    tbl[5] = '{1'b0, p8(0,511,3,3,511,0,256,1),    p8(0,0,1,3,3,256,511,511)};

    // Reset with arbitrary inputs and ena high, then ena low after release.
    rand_inputs(511);
    ena = 1'b1;
    @(posedge clk); #1;
    check_vec("reset_hold", zeros);
    ena = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      rand_inputs(511);
      tick();
      check_vec("post_reset_ena0", zeros);
    end

    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 8; i++) in_v[i] = tbl[t].in[i];
      dir = tbl[t].dir;
      ena = 1'b1;
      tick();
      for (int i = 0; i < 8; i++) e8[i] = tbl[t].exp[i];
      check_vec($sformatf("table_%0d", t), e8);
    end

    // Hold: outputs frozen while ena=0 regardless of input/direction churn.
    for (int i = 0; i < 8; i++) held[i] = tbl[5].exp[i];
    ena = 1'b0;
    for (int c = 0; c < 4; c++) begin
      rand_inputs(511);
      dir = ~dir;
      tick();
      check_vec("hold", held);
    end
    ena = 1'b1;
    dir = 1'b0;
    tick();
    check_vec("hold_release", exp_o);

    // Direction flip on unchanged data.
    for (int i = 0; i < 8; i++) in_v[i] = 9'(i * 60 + 11);
    tick();
    check_vec("dir_asc", exp_o);
    dir = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) e8[i] = (7 - i) * 60 + 11;
    check_vec("dir_flip_desc", e8);

    // Mid-stream reset: clears at once and discards the capture in that cycle.
    rand_inputs(511);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_vec("async_rst_now", zeros);
    tick();
    check_vec("async_rst_edge", zeros);
    @(negedge clk);
    rst = 1'b0;
    ena = 1'b0;
    tick();
    check_vec("after_rst_ena0", zeros);

    for (int c = 0; c < 1200; c++) begin
      rand_inputs(($urandom_range(3, 0) == 0) ? 3 : 511);
      dir = 1'(($urandom));
      ena = ($urandom_range(3, 0) != 0);
      tick();
      check_vec("random", exp_o);
      check_props("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
